// File: rtl/seg_pkg.sv
// seg_pkg: active-low {g..a} segment patterns, capture FSM states, and seg_decode() returning {legal, code}
package seg_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLING = 2'd1, CAPTURED = 2'd2} cap_state_t;
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      SEG_0:     return {1'b1, 4'd0};
      SEG_1:     return {1'b1, 4'd1};
      SEG_2:     return {1'b1, 4'd2};
      SEG_3:     return {1'b1, 4'd3};
      SEG_4:     return {1'b1, 4'd4};
      SEG_5:     return {1'b1, 4'd5};
      SEG_6:     return {1'b1, 4'd6};
      SEG_7:     return {1'b1, 4'd7};
      SEG_8:     return {1'b1, 4'd8};
      SEG_9:     return {1'b1, 4'd9};
      SEG_BLANK: return {1'b1, 4'hF};
      default:   return {1'b0, 4'hF};
    endcase
  endfunction
endpackage

// File: rtl/seg_settle.sv
// seg_settle: registers side/num, waits SETTLE stable cycles on a legal one-hot-low select, then strobes cap once with slot and seg (clk_org, async active-low reset)
module seg_settle import seg_pkg::*; #(
  parameter int SETTLE = 16
) (
  input  logic       clk_org,
  input  logic       reset,
  input  logic [3:0] side,
  input  logic [7:0] num,
  output logic       cap,
  output logic [1:0] slot,
  output logic [7:0] seg
);
  logic [3:0] s_r;
  logic [7:0] n_r;
  logic [7:0] cnt;
  logic       chg, sel_ok;
  cap_state_t state, state_n;
  assign chg     = {side, num} != {s_r, n_r};
  assign sel_ok  = $onehot(~side);
  assign cap     = state == SETTLING && !chg && cnt == 8'(SETTLE - 2);
  assign slot    = {~s_r[3] | ~s_r[2], ~s_r[3] | ~s_r[1]};
  assign seg     = n_r;
  assign state_n = chg ? (sel_ok ? SETTLING : IDLE) : cap ? CAPTURED : state;
  always_ff @(posedge clk_org or negedge reset)
    if (!reset) begin
      s_r   <= 4'hF;
      n_r   <= 8'hFF;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      s_r   <= side;
      n_r   <= num;
      cnt   <= (chg || !sel_ok) ? 8'd0 : (cnt == 8'(SETTLE - 1)) ? cnt : cnt + 8'd1;
      state <= state_n;
    end
endmodule

// File: rtl/seg_capture.sv
// seg_capture: 7-seg scan receiver (clk_org, async active-low reset, side/num scan in, clear) -> d0..d3, dp, valid, err, frame pulse, stale
module seg_capture import seg_pkg::*; #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic       clk_org,
  input  logic       reset,
  input  logic [3:0] side,
  input  logic [7:0] num,
  input  logic       clear,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] dp,
  output logic [3:0] valid,
  output logic [3:0] err,
  output logic       frame,
  output logic       stale
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic            cap;
  logic [1:0]      slot;
  logic [7:0]      seg;
  logic [4:0]      dec;
  logic [3:0][3:0] dig;
  logic [3:0]      seen, seen_n;
  logic [TW-1:0]   idle;
  seg_settle #(.SETTLE(SETTLE)) u_settle (
    .clk_org(clk_org),
    .reset  (reset),
    .side   (side),
    .num    (num),
    .cap    (cap),
    .slot   (slot),
    .seg    (seg)
  );
  assign dec             = seg_decode(seg[6:0]);
  assign seen_n          = seen | (4'b1 << slot);
  assign {d3, d2, d1, d0} = dig;
  assign stale           = idle == TW'(TIMEOUT);
  always_ff @(posedge clk_org or negedge reset)
    if (!reset) begin
      dig   <= {4{4'hF}};
      dp    <= '0;
      valid <= '0;
      err   <= '0;
      seen  <= '0;
      frame <= 1'b0;
      idle  <= '0;
    end else begin
      frame <= 1'b0;
      if (clear) begin
        valid <= '0;
        err   <= '0;
        seen  <= '0;
        idle  <= '0;
      end else if (cap) begin
        if (dec[4]) begin
          dig[slot]   <= dec[3:0];
          dp[slot]    <= !seg[7];
          valid[slot] <= 1'b1;
        end else
          err[slot] <= 1'b1;
        seen  <= (seen_n == 4'hF) ? 4'h0 : seen_n;
        frame <= seen_n == 4'hF;
        idle  <= '0;
      end else
        idle <= stale ? idle : idle + TW'(1);
    end
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed test-plan scans plus random scanning checked every cycle against a run-length behavioural model
module tb_seg_capture;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 64;
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp, valid, err, seen;
    logic        frame;
    logic [7:0]  idle;
    logic [11:0] prev;
    logic [15:0] run;
  } model_t;
  logic       clk_org = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] side = 4'hF;
  logic [7:0] num = 8'hFF;
  logic [3:0] d0, d1, d2, d3, dp, valid, err;
  logic       frame, stale;
  logic [3:0] rs;
  logic [7:0] rn;
  int         n_tests = 0, n_fail = 0, frames = 0, r, pat;
  int         pats [11] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10, 'h7F};
  model_t     m;
  always #5 clk_org = ~clk_org;
  seg_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk_org(clk_org),
    .reset  (reset),
    .side   (side),
    .num    (num),
    .clear  (clear),
    .d0     (d0),
    .d1     (d1),
    .d2     (d2),
    .d3     (d3),
    .dp     (dp),
    .valid  (valid),
    .err    (err),
    .frame  (frame),
    .stale  (stale)
  );
  function automatic model_t rst_model();
    model_t z = '0;
    z.d    = 16'hFFFF;
    z.prev = 12'hFFF;
    z.run  = 16'd1;
    return z;
  endfunction
  function automatic model_t step(model_t mi, logic [3:0] s, logic [7:0] n, logic clr);
    model_t o = mi;
    int     slot = 0, code = -1, p;
    o.frame = 1'b0;
    o.run   = ({s, n} == mi.prev) ? ((mi.run < 16'd1000) ? mi.run + 16'd1 : mi.run) : 16'd1;
    o.prev  = {s, n};
    if (clr) begin
      o.valid = '0;
      o.err   = '0;
      o.seen  = '0;
      o.idle  = '0;
    end else if ($countones(~s) == 1 && o.run == 16'(SETTLE)) begin
      for (int i = 0; i < 4; i++) if (!s[i]) slot = i;
      for (int i = 0; i < 11; i++) begin
        p = pats[i];
        if (n[6:0] == p[6:0]) code = (i == 10) ? 15 : i;
      end
      if (code >= 0) begin
        o.d[slot*4 +: 4] = code[3:0];
        o.dp[slot]       = !n[7];
        o.valid[slot]    = 1'b1;
      end else
        o.err[slot] = 1'b1;
      o.seen[slot] = 1'b1;
      if (o.seen == 4'hF) begin
        o.frame = 1'b1;
        o.seen  = '0;
      end
      o.idle = '0;
    end else if (o.idle < 8'(TIMEOUT))
      o.idle = o.idle + 8'd1;
    return o;
  endfunction
  always @(posedge clk_org or negedge reset)
    m <= !reset ? rst_model() : step(m, side, num, clear);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk_org) begin
    chk("d0", d0, m.d[3:0]);
    chk("d1", d1, m.d[7:4]);
    chk("d2", d2, m.d[11:8]);
    chk("d3", d3, m.d[15:12]);
    chk("dp", dp, m.dp);
    chk("valid", valid, m.valid);
    chk("err", err, m.err);
    chk("frame", frame, m.frame);
    chk("stale", stale, m.idle == 8'(TIMEOUT));
    if (frame) frames++;
  end
  task automatic hold(input logic [3:0] s, input logic [7:0] n, input int cyc, input logic clr);
    side  = s;
    num   = n;
    clear = clr;
    @(negedge clk_org);
    clear = 1'b0;
    repeat (cyc - 1) @(negedge clk_org);
  endtask
  initial begin
    repeat (3) @(negedge clk_org);
    reset = 1'b1;
    chk("rst_d0", d0, 4'hF);
    chk("rst_valid", valid, 4'h0);
    frames = 0;
    hold(4'b1110, 8'h40, 20, 1'b0);
    hold(4'b1101, 8'h79, 20, 1'b0);
    hold(4'b1011, 8'h24, 20, 1'b0);
    hold(4'b0111, 8'h30, 20, 1'b0);
    chk("t1_digits", {d3, d2, d1, d0}, 16'h3210);
    chk("t1_valid", valid, 4'hF);
    chk("t1_err", err, 4'h0);
    chk("t1_dp", dp, 4'hF);
    chk("t1_frames", frames, 1);
    hold(4'b1110, 8'h12, 10, 1'b0);
    hold(4'b1110, 8'h02, 15, 1'b0);
    chk("t2_before", d0, 4'h0);
    hold(4'b1110, 8'h02, 1, 1'b0);
    chk("t2_at16", d0, 4'h6);
    hold(4'b1110, 8'h02, 4, 1'b0);
    hold(4'b1011, 8'h7F, 20, 1'b0);
    chk("t3_d2", d2, 4'hF);
    chk("t3_dp2", dp[2], 1'b1);
    chk("t3_valid2", valid[2], 1'b1);
    hold(4'b1101, 8'h55, 20, 1'b0);
    chk("t4_err", err, 4'b0010);
    chk("t4_valid1", valid[1], 1'b1);
    chk("t4_d1", d1, 4'h1);
    hold(4'b1101, 8'h55, 1, 1'b1);
    chk("t4_clr_err", err, 4'h0);
    chk("t4_clr_valid", valid, 4'h0);
    hold(4'b1111, 8'hFF, 63, 1'b0);
    chk("t5_stale63", stale, 1'b0);
    hold(4'b1111, 8'hFF, 1, 1'b0);
    chk("t5_stale64", stale, 1'b1);
    hold(4'b1100, 8'hFF, 100, 1'b0);
    chk("t5_err", err, 4'h0);
    chk("t5_valid", valid, 4'h0);
    hold(4'b1110, 8'h79, 20, 1'b0);
    chk("t5_unstale", stale, 1'b0);
    chk("t5_d0", d0, 4'h1);
    hold(4'b1110, 8'h30, 9, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_d0", d0, 4'hF);
    chk("t6_rst_dp", dp, 4'h0);
    chk("t6_rst_valid", valid, 4'h0);
    @(negedge clk_org);
    reset = 1'b1;
    hold(4'b1110, 8'h30, 20, 1'b0);
    chk("t6_resume", d0, 4'h3);
    for (int k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 9);
      rs = (r < 7) ? ~(4'b1 << $urandom_range(0, 3)) : (r == 7) ? 4'hF : 4'($urandom);
      pat = pats[$urandom_range(0, 10)];
      rn = ($urandom_range(0, 9) < 7) ? {1'($urandom), pat[6:0]} : 8'($urandom);
      hold(rs, rn, $urandom_range(1, 40), $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk_org);
        reset = 1'b1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
